// File: rtl/wbxbc_arbiter.sv
// Round-robin arbiter sharing one pipelined Wishbone target among ITR_CNT
// pipelined Wishbone initiators. Whole bus cycles are granted: the owner
// keeps the bus from its first CYC cycle until it drops CYC.
//
// Handshake: a request transfers on a cycle where CYC & STB are high and
// STALL is low (STB is "valid", ~STALL is "ready"). The owner sees the
// target's STALL; every other initiator sees STALL=1 and no terminations.
module wbxbc_arbiter #(
    parameter int ITR_CNT    = 4,
    parameter int ADR_WIDTH  = 16,
    parameter int DAT_WIDTH  = 16,
    parameter int SEL_WIDTH  = 2,
    parameter int TGA_WIDTH  = 1,
    parameter int TGC_WIDTH  = 1,
    parameter int TGRD_WIDTH = 1,
    parameter int TGWD_WIDTH = 1
) (
    input  logic                            clk_i,
    input  logic                            async_rst_i,
    input  logic                            sync_rst_i,
    // initiator side
    input  logic [ITR_CNT-1:0]              itr_cyc_i,
    input  logic [ITR_CNT-1:0]              itr_stb_i,
    input  logic [ITR_CNT-1:0]              itr_we_i,
    input  logic [ITR_CNT-1:0]              itr_lock_i,
    input  logic [ITR_CNT*SEL_WIDTH-1:0]    itr_sel_i,
    input  logic [ITR_CNT*ADR_WIDTH-1:0]    itr_adr_i,
    input  logic [ITR_CNT*DAT_WIDTH-1:0]    itr_dat_i,
    input  logic [ITR_CNT*TGA_WIDTH-1:0]    itr_tga_i,
    input  logic [ITR_CNT*TGC_WIDTH-1:0]    itr_tgc_i,
    input  logic [ITR_CNT*TGWD_WIDTH-1:0]   itr_tgd_i,
    output logic [ITR_CNT-1:0]              itr_ack_o,
    output logic [ITR_CNT-1:0]              itr_err_o,
    output logic [ITR_CNT-1:0]              itr_rty_o,
    output logic [ITR_CNT-1:0]              itr_stall_o,
    output logic [DAT_WIDTH-1:0]            itr_dat_o,
    output logic [TGRD_WIDTH-1:0]           itr_tgd_o,
    // target side
    output logic                            tgt_cyc_o,
    output logic                            tgt_stb_o,
    output logic                            tgt_we_o,
    output logic                            tgt_lock_o,
    output logic [SEL_WIDTH-1:0]            tgt_sel_o,
    output logic [ADR_WIDTH-1:0]            tgt_adr_o,
    output logic [DAT_WIDTH-1:0]            tgt_dat_o,
    output logic [TGA_WIDTH-1:0]            tgt_tga_o,
    output logic [TGC_WIDTH-1:0]            tgt_tgc_o,
    output logic [TGWD_WIDTH-1:0]           tgt_tgd_o,
    input  logic                            tgt_ack_i,
    input  logic                            tgt_err_i,
    input  logic                            tgt_rty_i,
    input  logic                            tgt_stall_i,
    input  logic [DAT_WIDTH-1:0]            tgt_dat_i,
    input  logic [TGRD_WIDTH-1:0]           tgt_tgd_i
);

    localparam int                IDX_W    = (ITR_CNT > 1) ? $clog2(ITR_CNT) : 1;
    localparam logic [IDX_W-1:0]  LAST_RST = IDX_W'(ITR_CNT - 1);
    localparam logic [IDX_W:0]    CNT_W    = (IDX_W + 1)'(ITR_CNT);
    localparam logic [ITR_CNT-1:0] ONE_HOT0 = ITR_CNT'(1);

    logic [ITR_CNT-1:0]   grant_reg;
    logic [IDX_W-1:0]     last_reg;

    logic                 bus_free;
    logic [IDX_W-1:0]     start_idx;
    logic [ITR_CNT-1:0]   req_rot;
    logic                 scan_found;
    logic [IDX_W-1:0]     scan_ofs;
    logic [IDX_W:0]       scan_sum;
    logic [IDX_W-1:0]     scan_win;

    // The bus is free when nobody owns it or the owner has dropped CYC
    // (that also covers an owner aborting with accesses outstanding).
    assign bus_free = ~|(grant_reg & itr_cyc_i);

    // The scan starts just after the most recent owner, wrapping around.
    assign start_idx = (last_reg == LAST_RST) ? '0 : last_reg + 1'b1;
    assign req_rot   = ITR_CNT'({itr_cyc_i, itr_cyc_i} >> start_idx);

    // Find the first requester in rotated order (lowest offset wins).
    always_comb begin
        scan_found = 1'b0;
        scan_ofs   = '0;
        for (int j = ITR_CNT - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                scan_found = 1'b1;
                scan_ofs   = IDX_W'(j);
            end
        end
    end

    // Map the rotated offset back to an absolute initiator index.
    assign scan_sum = {1'b0, start_idx} + {1'b0, scan_ofs};
    assign scan_win = (scan_sum >= CNT_W) ? IDX_W'(scan_sum - CNT_W) : IDX_W'(scan_sum);

    // Grant register: only re-arbitrates while the bus is free, so an
    // owner holding CYC keeps the bus regardless of other requests.
    always_ff @(posedge clk_i or posedge async_rst_i) begin
        if (async_rst_i) begin
            grant_reg <= '0;
            last_reg  <= LAST_RST;
        end else if (sync_rst_i) begin
            grant_reg <= '0;
            last_reg  <= LAST_RST;
        end else if (bus_free) begin
            if (scan_found) begin
                grant_reg <= ONE_HOT0 << scan_win;
                last_reg  <= scan_win;
            end else begin
                grant_reg <= '0;
            end
        end
    end

    // Control strobes of the owner; zero whenever nobody is granted.
    assign tgt_cyc_o  = |(grant_reg & itr_cyc_i);
    assign tgt_stb_o  = |(grant_reg & itr_cyc_i & itr_stb_i);
    assign tgt_we_o   = |(grant_reg & itr_we_i);
    assign tgt_lock_o = |(grant_reg & itr_lock_i);

    // AND-OR mux of the owner's slices; all zero without a grant.
    always_comb begin
        tgt_sel_o = '0;
        tgt_adr_o = '0;
        tgt_dat_o = '0;
        tgt_tga_o = '0;
        tgt_tgc_o = '0;
        tgt_tgd_o = '0;
        for (int k = 0; k < ITR_CNT; k++) begin
            if (grant_reg[k]) begin
                tgt_sel_o = tgt_sel_o | itr_sel_i[k*SEL_WIDTH  +: SEL_WIDTH];
                tgt_adr_o = tgt_adr_o | itr_adr_i[k*ADR_WIDTH  +: ADR_WIDTH];
                tgt_dat_o = tgt_dat_o | itr_dat_i[k*DAT_WIDTH  +: DAT_WIDTH];
                tgt_tga_o = tgt_tga_o | itr_tga_i[k*TGA_WIDTH  +: TGA_WIDTH];
                tgt_tgc_o = tgt_tgc_o | itr_tgc_i[k*TGC_WIDTH  +: TGC_WIDTH];
                tgt_tgd_o = tgt_tgd_o | itr_tgd_i[k*TGWD_WIDTH +: TGWD_WIDTH];
            end
        end
    end

    // Terminations reach only an owner still holding CYC, so late responses
    // to an aborted cycle are dropped; everyone else is stalled.
    assign itr_ack_o   = {ITR_CNT{tgt_ack_i}} & grant_reg & itr_cyc_i;
    assign itr_err_o   = {ITR_CNT{tgt_err_i}} & grant_reg & itr_cyc_i;
    assign itr_rty_o   = {ITR_CNT{tgt_rty_i}} & grant_reg & itr_cyc_i;
    assign itr_stall_o = ~grant_reg | {ITR_CNT{tgt_stall_i}};

    // Read data and its tag are broadcast unregistered.
    assign itr_dat_o = tgt_dat_i;
    assign itr_tgd_o = tgt_tgd_i;

endmodule

// File: tb/tb_wbxbc_arbiter.sv
// Bench for wbxbc_arbiter with four initiators: a cycle-by-cycle vector
// table for grant/rotation behaviour, then hand sequences for pipelined
// reads, error routing, sync reset abort and asynchronous reset.
module tb_wbxbc_arbiter;

    localparam int N  = 4;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int SW = 2;

    // clock / reset
    logic clk_i = 1'b0;
    logic async_rst_i;
    logic sync_rst_i;
    always #5 clk_i = ~clk_i;

    logic [N-1:0]    itr_cyc_i, itr_stb_i, itr_we_i, itr_lock_i;
    logic [N*SW-1:0] itr_sel_i;
    logic [N*AW-1:0] itr_adr_i;
    logic [N*DW-1:0] itr_dat_i;
    logic [N-1:0]    itr_tga_i, itr_tgc_i, itr_tgd_i;
    logic [N-1:0]    itr_ack_o, itr_err_o, itr_rty_o, itr_stall_o;
    logic [DW-1:0]   itr_dat_o;
    logic [0:0]      itr_tgd_o;
    logic            tgt_cyc_o, tgt_stb_o, tgt_we_o, tgt_lock_o;
    logic [SW-1:0]   tgt_sel_o;
    logic [AW-1:0]   tgt_adr_o;
    logic [DW-1:0]   tgt_dat_o;
    logic [0:0]      tgt_tga_o, tgt_tgc_o, tgt_tgd_o;
    logic            tgt_ack_i, tgt_err_i, tgt_rty_i, tgt_stall_i;
    logic [DW-1:0]   tgt_dat_i;
    logic [0:0]      tgt_tgd_i;

    wbxbc_arbiter #(
        .ITR_CNT(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW),
        .TGA_WIDTH(1), .TGC_WIDTH(1), .TGRD_WIDTH(1), .TGWD_WIDTH(1)
    ) dut (
        .clk_i(clk_i), .async_rst_i(async_rst_i), .sync_rst_i(sync_rst_i),
        .itr_cyc_i(itr_cyc_i), .itr_stb_i(itr_stb_i), .itr_we_i(itr_we_i),
        .itr_lock_i(itr_lock_i), .itr_sel_i(itr_sel_i), .itr_adr_i(itr_adr_i),
        .itr_dat_i(itr_dat_i), .itr_tga_i(itr_tga_i), .itr_tgc_i(itr_tgc_i),
        .itr_tgd_i(itr_tgd_i), .itr_ack_o(itr_ack_o), .itr_err_o(itr_err_o),
        .itr_rty_o(itr_rty_o), .itr_stall_o(itr_stall_o), .itr_dat_o(itr_dat_o),
        .itr_tgd_o(itr_tgd_o), .tgt_cyc_o(tgt_cyc_o), .tgt_stb_o(tgt_stb_o),
        .tgt_we_o(tgt_we_o), .tgt_lock_o(tgt_lock_o), .tgt_sel_o(tgt_sel_o),
        .tgt_adr_o(tgt_adr_o), .tgt_dat_o(tgt_dat_o), .tgt_tga_o(tgt_tga_o),
        .tgt_tgc_o(tgt_tgc_o), .tgt_tgd_o(tgt_tgd_o), .tgt_ack_i(tgt_ack_i),
        .tgt_err_i(tgt_err_i), .tgt_rty_i(tgt_rty_i), .tgt_stall_i(tgt_stall_i),
        .tgt_dat_i(tgt_dat_i), .tgt_tgd_i(tgt_tgd_i)
    );

    // scoreboard state
    logic [DW-1:0] exp_q[$];
    int n_vec  = 0;
    int n_fail = 0;

    typedef struct {
        logic          srst;
        logic [N-1:0]  cyc;
        logic [N-1:0]  stb;
        logic          ack;
        logic          stall;
        logic          e_cyc;
        logic          e_stb;
        logic [N-1:0]  e_stall;
        logic [N-1:0]  e_ack;
        logic [AW-1:0] e_adr;
    } vec_t;

    vec_t vecs[18];

    // driver tasks
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    logic [AW-1:0] adr_list[3];
    logic          pend_v;
    logic [DW-1:0] pend_d;
    int            issued, acked;

    initial begin
        // vector table: inputs for the cycle, expected outputs in that cycle
        vecs[0]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};
        vecs[1]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};
        vecs[2]  = '{1'b0, 4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 4'b0000, 16'hA002};
        vecs[3]  = '{1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b0100, 16'hA002};
        vecs[4]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1011, 4'b0000, 16'hA002};
        vecs[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};
        vecs[6]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};
        vecs[7]  = '{1'b0, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};
        vecs[8]  = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1110, 4'b0001, 16'hA000};
        vecs[9]  = '{1'b0, 4'b1010, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0000, 16'hA000};
        vecs[10] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b1101, 4'b0010, 16'hA001};
        vecs[11] = '{1'b0, 4'b1001, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1101, 4'b0000, 16'hA001};
        vecs[12] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b1000, 16'hA003};
        vecs[13] = '{1'b0, 4'b0011, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0111, 4'b0000, 16'hA003};
        vecs[14] = '{1'b0, 4'b1011, 4'b1011, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1110, 4'b0000, 16'hA000};
        vecs[15] = '{1'b0, 4'b1011, 4'b1011, 1'b0, 1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000, 16'hA000};
        vecs[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 4'b0000, 16'hA000};
        vecs[17] = '{1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0000, 16'h0000};

        // static per-initiator payload
        for (int k = 0; k < N; k++) begin
            itr_adr_i[k*AW +: AW] = 16'hA000 + 16'(k);
            itr_dat_i[k*DW +: DW] = 16'hD000 + 16'(k);
            itr_sel_i[k*SW +: SW] = 2'(k);
        end
        itr_we_i   = 4'b1010;
        itr_lock_i = 4'b1000;
        itr_tga_i  = 4'b1010;
        itr_tgc_i  = 4'b1010;
        itr_tgd_i  = 4'b1010;

        // reset with noisy requests and responses: everything must stay gated
        async_rst_i = 1'b1;
        sync_rst_i  = 1'b0;
        itr_cyc_i   = 4'b1111;
        itr_stb_i   = 4'b1111;
        tgt_ack_i   = 1'b1;
        tgt_err_i   = 1'b1;
        tgt_rty_i   = 1'b1;
        tgt_stall_i = 1'b0;
        tgt_dat_i   = 16'h1234;
        tgt_tgd_i   = 1'b1;
        #12;
        check("rst.cyc",   tgt_cyc_o, 1'b0);
        check("rst.stb",   tgt_stb_o, 1'b0);
        check("rst.we",    tgt_we_o, 1'b0);
        check("rst.lock",  tgt_lock_o, 1'b0);
        check("rst.adr",   tgt_adr_o, 16'h0000);
        check("rst.sel",   tgt_sel_o, 2'b00);
        check("rst.dat",   tgt_dat_o, 16'h0000);
        check("rst.stall", itr_stall_o, 4'b1111);
        check("rst.ack",   itr_ack_o, 4'b0000);
        check("rst.err",   itr_err_o, 4'b0000);
        check("rst.rty",   itr_rty_o, 4'b0000);
        check("rst.rdat",  itr_dat_o, 16'h1234);
        async_rst_i = 1'b0;
        itr_cyc_i   = '0;
        itr_stb_i   = '0;
        tgt_ack_i   = 1'b0;
        tgt_err_i   = 1'b0;
        tgt_rty_i   = 1'b0;

        // table-driven grant, hold, rotation and sync reset behaviour
        for (int i = 0; i < 18; i++) begin
            step();
            sync_rst_i  = vecs[i].srst;
            itr_cyc_i   = vecs[i].cyc;
            itr_stb_i   = vecs[i].stb;
            tgt_ack_i   = vecs[i].ack;
            tgt_stall_i = vecs[i].stall;
            settle();
            check($sformatf("v%0d.tgt_cyc", i), tgt_cyc_o, vecs[i].e_cyc);
            check($sformatf("v%0d.tgt_stb", i), tgt_stb_o, vecs[i].e_stb);
            check($sformatf("v%0d.stall", i),   itr_stall_o, vecs[i].e_stall);
            check($sformatf("v%0d.ack", i),     itr_ack_o, vecs[i].e_ack);
            check($sformatf("v%0d.adr", i),     tgt_adr_o, vecs[i].e_adr);
        end
        tgt_ack_i   = 1'b0;
        tgt_stall_i = 1'b0;

        // pipelined reads by initiator 1 while initiator 2 waits
        adr_list[0] = 16'h0010;
        adr_list[1] = 16'h0012;
        adr_list[2] = 16'h0014;
        pend_v = 1'b0;
        pend_d = '0;
        issued = 0;
        acked  = 0;
        step();
        itr_cyc_i = 4'b0110;
        itr_stb_i = 4'b0010;
        itr_adr_i[1*AW +: AW] = adr_list[0];
        settle();
        check("a.req_stall", itr_stall_o, 4'b1111);
        for (int c = 0; c < 10 && acked < 3; c++) begin
            step();
            tgt_ack_i   = pend_v;
            tgt_dat_i   = pend_d;
            pend_v      = 1'b0;
            tgt_stall_i = (c == 2);
            if (issued < 3) begin
                itr_stb_i = 4'b0010;
                itr_adr_i[1*AW +: AW] = adr_list[issued];
            end else begin
                itr_stb_i = 4'b0000;
            end
            settle();
            check("a.stall1", itr_stall_o[1], tgt_stall_i);
            check("a.stall2", itr_stall_o[2], 1'b1);
            check("a.other_ack", itr_ack_o & 4'b1101, 4'b0000);
            if (itr_ack_o[1]) begin
                check("a.q_nonempty", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) check("a.rdat", itr_dat_o, exp_q.pop_front());
                acked++;
            end
            if (issued < 3) begin
                check("a.adr", tgt_adr_o, adr_list[issued]);
                if (!tgt_stall_i) begin
                    exp_q.push_back(16'h5A00 ^ adr_list[issued]);
                    pend_v = 1'b1;
                    pend_d = 16'h5A00 ^ tgt_adr_o;
                    issued++;
                end
            end
        end
        check("a.acks", acked, 3);
        check("a.q_empty", exp_q.size(), 0);
        step();
        tgt_ack_i = 1'b0;
        itr_cyc_i = 4'b0100;
        itr_stb_i = 4'b0000;
        settle();
        check("a.drop_cyc", tgt_cyc_o, 1'b0);
        check("a.drop_stall2", itr_stall_o[2], 1'b1);
        step();
        settle();
        check("a.h2_cyc", tgt_cyc_o, 1'b1);
        check("a.h2_stall", itr_stall_o, 4'b1011);
        check("a.h2_adr", tgt_adr_o, 16'hA002);

        // error to owner 0 while initiator 3 waits
        step();
        itr_cyc_i = 4'b0000;
        step();
        itr_cyc_i = 4'b0001;
        step();
        itr_cyc_i = 4'b1001;
        tgt_err_i = 1'b1;
        settle();
        check("b.err", itr_err_o, 4'b0001);
        check("b.ack", itr_ack_o, 4'b0000);
        check("b.stall", itr_stall_o, 4'b1110);
        step();
        tgt_err_i = 1'b0;
        tgt_rty_i = 1'b1;
        settle();
        check("b.rty", itr_rty_o, 4'b0001);
        check("b.hold_adr", tgt_adr_o, 16'hA000);
        check("b.hold_stall", itr_stall_o, 4'b1110);
        check("b.we0", tgt_we_o, 1'b0);
        check("b.lock0", tgt_lock_o, 1'b0);
        step();
        tgt_rty_i = 1'b0;
        itr_cyc_i = 4'b1000;
        settle();
        check("b.drop_cyc", tgt_cyc_o, 1'b0);
        check("b.wait3", itr_stall_o[3], 1'b1);
        step();
        tgt_dat_i = 16'hBEEF;
        tgt_tgd_i = 1'b1;
        settle();
        check("b.g3_cyc", tgt_cyc_o, 1'b1);
        check("b.g3_stall", itr_stall_o, 4'b0111);
        check("b.g3_adr", tgt_adr_o, 16'hA003);
        check("b.g3_sel", tgt_sel_o, 2'b11);
        check("b.g3_dat", tgt_dat_o, 16'hD003);
        check("b.g3_we", tgt_we_o, 1'b1);
        check("b.g3_lock", tgt_lock_o, 1'b1);
        check("b.g3_tags", {tgt_tga_o, tgt_tgc_o, tgt_tgd_o}, 3'b111);
        check("b.rdat_bcast", itr_dat_o, 16'hBEEF);
        check("b.rtgd_bcast", itr_tgd_o, 1'b1);

        // sync reset while owner 2 has an access outstanding
        step();
        itr_cyc_i = 4'b0000;
        step();
        itr_cyc_i = 4'b0100;
        itr_stb_i = 4'b0100;
        settle();
        check("c.req_stall", itr_stall_o, 4'b1111);
        step();
        settle();
        check("c.g2_stb", tgt_stb_o, 1'b1);
        check("c.g2_stall", itr_stall_o, 4'b1011);
        step();
        sync_rst_i = 1'b1;
        itr_stb_i  = 4'b0000;
        settle();
        check("c.srst_cyc", tgt_cyc_o, 1'b1);
        step();
        sync_rst_i = 1'b0;
        itr_cyc_i  = 4'b1100;
        tgt_ack_i  = 1'b1;
        tgt_rty_i  = 1'b1;
        settle();
        check("c.post_cyc", tgt_cyc_o, 1'b0);
        check("c.late_ack", itr_ack_o, 4'b0000);
        check("c.late_rty", itr_rty_o, 4'b0000);
        check("c.post_stall", itr_stall_o, 4'b1111);
        step();
        tgt_ack_i = 1'b0;
        tgt_rty_i = 1'b0;
        settle();
        check("c.restart_stall", itr_stall_o, 4'b1011);
        check("c.restart_adr", tgt_adr_o, 16'hA002);
        check("c.restart_cyc", tgt_cyc_o, 1'b1);

        // asynchronous reset between edges during a grant
        step();
        tgt_ack_i = 1'b1;
        #1;
        check("d.pre_cyc", tgt_cyc_o, 1'b1);
        check("d.pre_ack", itr_ack_o, 4'b0100);
        #1;
        async_rst_i = 1'b1;
        #1;
        check("d.cyc", tgt_cyc_o, 1'b0);
        check("d.stb", tgt_stb_o, 1'b0);
        check("d.adr", tgt_adr_o, 16'h0000);
        check("d.stall", itr_stall_o, 4'b1111);
        check("d.ack", itr_ack_o, 4'b0000);
        #1;
        async_rst_i = 1'b0;
        tgt_ack_i   = 1'b0;
        itr_cyc_i   = 4'b0000;
        step();
        settle();
        check("d.idle_cyc", tgt_cyc_o, 1'b0);
        check("d.idle_stall", itr_stall_o, 4'b1111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
